// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared types and constants for the LED pattern sequencer.
//   - mode_e  : requested pattern (value matches the mode_sel encoding)
//   - state_e : pattern FSM state
//   - duty_max(): full-scale duty for a given PWM width
//   - CHASE_TAIL*_SHIFT: right-shift of full scale for the two chase tail LEDs
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_RAMP    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_BR_UP,
        S_BR_DN,
        S_CHASE,
        S_RAMP
    } state_e;

    localparam int unsigned CHASE_TAIL1_SHIFT = 1;
    localparam int unsigned CHASE_TAIL2_SHIFT = 2;

    function automatic int unsigned duty_max(int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Entry state of the pattern FSM for a freshly accepted mode.
    function automatic state_e mode_init_state(mode_e m);
        case (m)
            MODE_BREATHE: return S_BR_UP;
            MODE_CHASE:   return S_CHASE;
            MODE_RAMP:    return S_RAMP;
            default:      return S_OFF;
        endcase
    endfunction

endpackage

// File: rtl/pwm_bank.sv
// pwm_bank
//   Eight PWM channels sharing one free-running counter.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     duty_nxt  : next duty per channel, sampled only at the period boundary
//     led       : registered PWM outputs, led[i] = duty_act[i] > pwm_cnt
module pwm_bank
    import led_seq_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0][PWM_BITS-1:0] duty_nxt,
    output logic [7:0]               led
);

    logic [PWM_BITS-1:0]       pwm_cnt_q;
    logic [7:0][PWM_BITS-1:0]  duty_act_q;
    logic [7:0]                led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            duty_act_q <= '0;
            led_q      <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            // Loading only on the last count keeps every period whole.
            if (pwm_cnt_q == '1) begin
                duty_act_q <= duty_nxt;
            end
            for (int unsigned i = 0; i < 8; i++) begin
                led_q[i] <= (duty_act_q[i] > pwm_cnt_q);
            end
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_sequencer.sv
// led_pwm_sequencer
//   Pattern controller for the eight onboard LEDs: step prescaler, pattern
//   FSM (off / breathe / chase / ramp), mode req/ack handshake and duty
//   generation feeding an 8-channel PWM bank.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     run       : 1 = pattern advances, 0 = pattern frozen (PWM keeps running)
//     mode_req  : mode change request, held until mode_ack
//     mode_sel  : requested mode (0 OFF, 1 BREATHE, 2 CHASE, 3 RAMP)
//     mode_ack  : one-cycle acceptance pulse
//     step_tick : one-cycle pulse per pattern step
//     busy      : current mode is not OFF
//     led       : PWM outputs
module led_pwm_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned STEP_DIV = 781250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_req,
    input  logic [1:0] mode_sel,
    output logic       mode_ack,
    output logic       step_tick,
    output logic       busy,
    output logic [7:0] led
);

    localparam int unsigned         PRESC_W    = $clog2(STEP_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = PWM_BITS'(duty_max(PWM_BITS));

    logic [PRESC_W-1:0]       presc_q, presc_d;
    logic                     ack_q, tick_q;
    logic                     accept, terminal;
    mode_e                    mode_q;
    state_e                   state_q;
    logic [PWM_BITS-1:0]      d_q;
    logic [2:0]               p_q;
    logic [7:0][PWM_BITS-1:0] duty_nxt;

    // A request is taken whenever it is high outside the ack cycle, so a
    // requester that keeps mode_req high past the ack is accepted again.
    assign accept   = mode_req & ~ack_q;
    assign terminal = run & (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (accept) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = terminal ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ack_q   <= accept;
            // A mode change landing on the terminal count swallows that step.
            tick_q  <= terminal & ~accept;
        end
    end

    // Pattern FSM; a step is applied the cycle after step_tick, and a
    // request accepted in that same cycle takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            state_q <= S_OFF;
            d_q     <= '0;
            p_q     <= '0;
        end else if (accept) begin
            mode_q  <= mode_e'(mode_sel);
            state_q <= mode_init_state(mode_e'(mode_sel));
            d_q     <= '0;
            p_q     <= '0;
        end else if (tick_q) begin
            case (state_q)
                S_BR_UP: begin
                    d_q <= d_q + PWM_BITS'(1);
                    if (d_q == (DUTY_MAX - PWM_BITS'(1))) begin
                        state_q <= S_BR_DN;
                    end
                end
                S_BR_DN: begin
                    d_q <= d_q - PWM_BITS'(1);
                    if (d_q == PWM_BITS'(1)) begin
                        state_q <= S_BR_UP;
                    end
                end
                S_CHASE: p_q <= p_q + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        duty_nxt = '0;
        case (state_q)
            S_BR_UP, S_BR_DN: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    duty_nxt[i] = d_q;
                end
            end
            S_CHASE: begin
                // 3-bit wrap of p-1 / p-2 gives the mod-8 tail positions.
                duty_nxt[p_q]        = DUTY_MAX;
                duty_nxt[p_q - 3'd1] = DUTY_MAX >> CHASE_TAIL1_SHIFT;
                duty_nxt[p_q - 3'd2] = DUTY_MAX >> CHASE_TAIL2_SHIFT;
            end
            S_RAMP: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    duty_nxt[i] = PWM_BITS'(2 * i);
                end
            end
            default: ;
        endcase
    end

    pwm_bank #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_bank (
        .clk      (clk),
        .rst      (rst),
        .duty_nxt (duty_nxt),
        .led      (led)
    );

    assign mode_ack  = ack_q;
    assign step_tick = tick_q;
    assign busy      = (mode_q != MODE_OFF);

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// tb_led_pwm_sequencer
//   Self-checking bench for led_pwm_sequencer with PWM_BITS=4, STEP_DIV=4.
//   Per-LED high counts over one aligned PWM period are compared against
//   expected duty patterns queued when the stimulus is applied.
module tb_led_pwm_sequencer;

    typedef logic [7:0][4:0] pat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic       step_tick;
    logic       busy;
    logic [7:0] led;

    int   checks = 0;
    int   errors = 0;
    pat_t exp_q[$];

    // Independent model of the shared PWM counter.
    logic [3:0] tb_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 4'd0;
        else     tb_cnt <= tb_cnt + 4'd1;
    end

    led_pwm_sequencer #(
        .PWM_BITS (4),
        .STEP_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode_req  (mode_req),
        .mode_sel  (mode_sel),
        .mode_ack  (mode_ack),
        .step_tick (step_tick),
        .busy      (busy),
        .led       (led)
    );

    function automatic pat_t pat_all(int v);
        pat_t r;
        for (int i = 0; i < 8; i++) r[i] = 5'(v);
        return r;
    endfunction

    function automatic pat_t pat_chase(int p);
        pat_t r;
        r = '0;
        r[p % 8]       = 5'd15;
        r[(p + 7) % 8] = 5'd7;
        r[(p + 6) % 8] = 5'd3;
        return r;
    endfunction

    function automatic pat_t pat_ramp();
        pat_t r;
        for (int i = 0; i < 8; i++) r[i] = 5'(2 * i);
        return r;
    endfunction

    function automatic int br_d(int k);
        int m;
        m = k % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction

    // Count high samples per LED over one whole period of constant duty_act.
    // Returns on a negedge.
    task automatic measure(output pat_t m);
        m = '0;
        @(negedge clk);
        while (tb_cnt != 4'd2) @(negedge clk);
        while (tb_cnt != 4'd1) @(negedge clk);
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 8; i++) begin
                if (led[i] === 1'b1) m[i] = m[i] + 5'd1;
            end
            if (s < 15) @(negedge clk);
        end
    endtask

    // Waits (bounded) for a step_tick pulse; returns on that negedge.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (step_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on a negedge; raises the request for one cycle.
    task automatic request(input logic [1:0] m, output logic a1,
                           output logic b1, output logic a2);
        mode_req = 1'b1;
        mode_sel = m;
        @(negedge clk);
        a1 = mode_ack;
        b1 = busy;
        mode_req = 1'b0;
        @(negedge clk);
        a2 = mode_ack;
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1; run = 1'b0; mode_req = 1'b0; mode_sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({led, mode_ack, step_tick, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b required 0", {led, mode_ack, step_tick, busy});
        end
        rst = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (led !== 8'd0 || busy !== 1'b0 || step_tick !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_idle: got activity required led=0 busy=0 tick=0");
        end
    endtask

    task automatic test_breathe();
        logic a1, b1, a2;
        bit   ok;
        pat_t m, e;
        run = 1'b0;
        exp_q.push_back(pat_all(0));
        request(2'd1, a1, b1, a2);
        checks++;
        if ({a1, b1, a2} !== 3'b110) begin
            errors++;
            $display("FAIL breathe_ack: got ack/busy/ack2=%b required 110", {a1, b1, a2});
        end
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL breathe_d0: got %h required %h", m, e);
        end
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(pat_all(br_d(k)));
            run = 1'b1;
            wait_tick(ok);
            run = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL breathe_tick: got no tick at step %0d required tick", k);
            end
            measure(m);
            e = exp_q.pop_front();
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL breathe_step%0d: got %h required %h", k, m, e);
            end
        end
    endtask

    task automatic test_run_freeze();
        bit   ok, okall, saw;
        int   n;
        pat_t m, e;
        okall = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_tick(ok);
            if (!ok) okall = 1'b0;
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (!okall) begin
            errors++;
            $display("FAIL freeze_ticks: got missing tick required 5 ticks");
        end
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (step_tick !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL freeze_no_tick: got tick while run=0 required none");
        end
        exp_q.push_back(pat_all(5));
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL freeze_d5: got %h required %h", m, e);
        end
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_tick !== 1'b1 && n < 10);
        run = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL resume_latency: got %0d cycles required 3", n);
        end
        exp_q.push_back(pat_all(6));
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL resume_d6: got %h required %h", m, e);
        end
    endtask

    task automatic test_chase();
        logic a1, b1, a2;
        bit   ok;
        pat_t m, e;
        exp_q.push_back(pat_chase(0));
        request(2'd2, a1, b1, a2);
        checks++;
        if ({a1, b1, a2} !== 3'b110) begin
            errors++;
            $display("FAIL chase_ack: got ack/busy/ack2=%b required 110", {a1, b1, a2});
        end
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL chase_p0: got %h required %h", m, e);
        end
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(pat_chase(k));
            run = 1'b1;
            wait_tick(ok);
            run = 1'b0;
            measure(m);
            e = exp_q.pop_front();
            checks++;
            if (!ok || m !== e) begin
                errors++;
                $display("FAIL chase_step%0d: got tick=%0d %h required tick=1 %h", k, ok, m, e);
            end
        end
    endtask

    task automatic test_collision();
        bit   ok1, ok2;
        pat_t m, e;
        // prescaler sits at 0 here; three running cycles bring it to the terminal count
        run = 1'b1;
        repeat (3) @(negedge clk);
        mode_req = 1'b1;
        mode_sel = 2'd3;
        exp_q.push_back(pat_ramp());
        @(negedge clk);
        checks++;
        if (step_tick !== 1'b0 || mode_ack !== 1'b1) begin
            errors++;
            $display("FAIL collision: got tick=%b ack=%b required tick=0 ack=1", step_tick, mode_ack);
        end
        mode_req = 1'b0;
        run = 1'b0;
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL ramp_duty: got %h required %h", m, e);
        end
        exp_q.push_back(pat_ramp());
        run = 1'b1;
        wait_tick(ok1);
        wait_tick(ok2);
        run = 1'b0;
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (!ok1 || !ok2 || m !== e) begin
            errors++;
            $display("FAIL ramp_static: got ticks=%0d%0d %h required 11 %h", ok1, ok2, m, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        bit   ok;
        int   nack;
        pat_t m, e;
        mode_req = 1'b1;
        mode_sel = 2'd1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acks[3 - c] = mode_ack;
            if (c == 2) mode_req = 1'b0;
        end
        checks++;
        if (acks !== 4'b1010) begin
            errors++;
            $display("FAIL held_req_acks: got %b required 1010", acks);
        end
        exp_q.push_back(pat_all(3));
        run = 1'b1;
        for (int k = 0; k < 3; k++) wait_tick(ok);
        run = 1'b0;
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL held_req_d3: got %h required %h", m, e);
        end
        // re-request of the current mode restarts the pattern
        exp_q.push_back(pat_all(0));
        mode_req = 1'b1;
        mode_sel = 2'd1;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mode_ack === 1'b1) begin
                nack++;
                mode_req = 1'b0;
            end
        end
        mode_req = 1'b0;
        checks++;
        if (nack != 1) begin
            errors++;
            $display("FAIL single_ack: got %0d acks required 1", nack);
        end
        measure(m);
        e = exp_q.pop_front();
        checks++;
        if (m !== e) begin
            errors++;
            $display("FAIL restart_d0: got %h required %h", m, e);
        end
    endtask

    task automatic test_reset_mid();
        logic a1, b1, a2;
        logic bad;
        request(2'd2, a1, b1, a2);
        run = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({led, mode_ack, step_tick, busy} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {led, mode_ack, step_tick, busy});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        bad = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (led !== 8'd0 || busy !== 1'b0 || mode_ack !== 1'b0) bad = 1'b1;
        end
        run = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle: got activity required led=0 busy=0 ack=0");
        end
    endtask

    initial begin
        test_reset();
        test_breathe();
        test_run_freeze();
        test_chase();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/led_pwm_sequencer.md
# led_pwm_sequencer

Pattern controller for the eight onboard LEDs. Owns an 8-channel PWM bank driven by one shared free-running counter. Steps per-LED duty values through selectable patterns (off, breathe, chase, static ramp) on a programmable step tick. Mode changes arrive over a req/ack handshake from top-level control logic. The block replaces ad-hoc single-LED blinkers and fixed-duty PWM instances in the top level.

## Interface
- PWM_BITS, 4: duty/counter width; PWM period = 2^PWM_BITS cycles
- STEP_DIV, 781250: clk cycles per pattern step (15.6 ms at 50 MHz); must be ≥2
- clk  input  1  system clock (50 MHz)
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- run  input  1  1 = pattern advances; 0 = pattern frozen, PWM keeps running
- mode_req  input  1  mode change request; held high until mode_ack
- mode_sel  input  2  requested mode; stable while mode_req high
- mode_ack  output  1  one-cycle pulse: request accepted
- step_tick  output  1  one-cycle pulse on each pattern step
- busy  output  1  1 when current mode != OFF
- led  output  8  PWM outputs, one per LED

## Operation
- Modes (mode_sel): 0 OFF, 1 BREATHE, 2 CHASE, 3 RAMP.
- FSM states: S_OFF, S_BR_UP, S_BR_DN, S_CHASE, S_RAMP.
- OFF: all duty 0.
- BREATHE: all LEDs share duty d. S_BR_UP increments d per step; at d=MAX (2^PWM_BITS-1) it goes to S_BR_DN. S_BR_DN decrements; at d=0 it goes to S_BR_UP. Sequence 0,1..15,14..1,0,1..; period 30 steps.
- CHASE: position p (3 bits) increments mod 8 per step.
  - duty[p]=MAX; duty[p-1 mod 8]=MAX>>1; duty[p-2 mod 8]=MAX>>2; others 0.
- RAMP: static; duty[i]=i*2 (0,2,..,14). Step ticks are ignored.
- Handshake: when mode_req=1 and mode_ack=0, the block accepts the request.
  - mode_ack pulses the following cycle.
  - In the same acceptance cycle:
    - mode register and FSM take the new mode's initial state (BREATHE: S_BR_UP, d=0; CHASE: p=0).
    - The prescaler clears to 0.
  - The requester drops mode_req after ack. If mode_req is still high the cycle after ack, it counts as a new request.
- Prescaler counts 0..STEP_DIV-1 while run=1, wraps to 0, and pulses step_tick at the terminal count. It holds its value while run=0. step_tick never asserts while run=0.
- PWM: pwm_cnt increments every cycle and wraps MAX→0. led[i] is registered as (duty_act[i] > pwm_cnt).
  - duty 0: always off.
  - duty MAX: on for MAX/2^PWM_BITS of the period.
- duty_act (active duty) loads from the pattern's next-duty registers only when pwm_cnt==MAX. No mid-period glitch.

## Timing
- Reset values:
  - led=0, mode_ack=0, step_tick=0, busy=0
  - mode=OFF, FSM S_OFF
  - pwm_cnt=0, prescaler=0, d=0, p=0, all duty registers 0
- led latency: duty change at a period boundary is visible on led 1 cycle after pwm_cnt=0.
- Pattern update happens the cycle after step_tick. It reaches led at the next PWM period boundary.
- busy updates in the acceptance cycle and is visible the cycle after it, coincident with mode_ack.
- Request in the same cycle as a prescaler terminal count: the mode change wins. No step is applied to the old pattern, and step_tick is suppressed.
- Request for the current mode: still acknowledged, and the pattern restarts from its initial state.
- Async reset mid-operation: all outputs go to reset values immediately. A pending request is dropped; the requester must re-assert it.

## Structure
- Package led_seq_pkg holds:
  - the mode enum (OFF/BREATHE/CHASE/RAMP) and FSM state enum
  - the MAX duty constant function
  - chase tail shift amounts (1, 2)
- Sub-module pwm_bank(clk, rst, duty_nxt[8], led[8]) holds:
  - the shared pwm_cnt
  - boundary loading of duty_act
  - the registered compares
- The top of the block holds the prescaler, FSM, handshake and duty generation.

## Test plan
Simulation uses STEP_DIV=4 and PWM_BITS=4.
- Reset: assert rst mid-CHASE → led=0, busy=0, mode_ack=0 asynchronously. After release, all leds stay 0 for 64 cycles.
- BREATHE: request mode 1 with run=1.
  - mode_ack is one cycle.
  - Sampled d follows 0,1,..15,14..0 over 30 step_ticks.
  - With d=8, each led is high for exactly 8 of every 16 cycles.
- CHASE: request mode 2 and count 8 steps. Per step, led duty pattern (LED7..0 high-counts per period):
  - step 0: 15 on LED0, 7 on LED7, 3 on LED6
  - p=1: 15 on LED1, 7 on LED0, 3 on LED7
  - p wraps 7→0 on the 8th step.
- run=0 for 40 cycles in BREATHE at d=5 → no step_tick, d stays 5, PWM high 5/16. Re-enable → next tick after the remaining prescaler count.
- Request colliding with a prescaler terminal count, CHASE→RAMP → no step_tick that cycle, mode_ack next cycle. Duty settles to 0,2..14 at the next period boundary, and led shows no partial period.
- mode_req held high for 3 cycles → ack in cycle 2. A second ack in cycle 4 signals re-acceptance; the bench checks for exactly one ack after a proper drop.
